// File: rtl/ddr3_tg_pkg.sv
// Shared types for the DDR3 FIFO traffic generator.
// Holds the run-state encoding and the index/counter width.
package ddr3_tg_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_WRITE     = 3'd2,
        S_SETTLE1   = 3'd3,
        S_RCLR      = 3'd4,
        S_SETTLE2   = 3'd5,
        S_READ      = 3'd6,
        S_DONE      = 3'd7
    } tg_state_t;

endpackage

// File: rtl/ddr3_tg_checker.sv
// Read-back checker: compares rd_fifo data one cycle after rden.
// Ports: clk, reset, clear, rd_en, rd_idx, rd_data -> cmp_cnt, err_cnt, first_err_idx.
module ddr3_tg_checker
    import ddr3_tg_pkg::*;
#(
    parameter int FIFO_DW    = 16,
    parameter int DATA_BEGIN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               rd_en,
    input  logic [CNT_W-1:0]   rd_idx,
    input  logic [FIFO_DW-1:0] rd_data,
    output logic [CNT_W-1:0]   cmp_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   first_err_idx
);

    logic               vld_q;
    logic [CNT_W-1:0]   idx_q;
    logic [FIFO_DW-1:0] exp_data;
    logic               miss;

    assign exp_data = FIFO_DW'(DATA_BEGIN) + FIFO_DW'(idx_q);
    assign miss     = vld_q && (rd_data != exp_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q         <= 1'b0;
            idx_q         <= '0;
            cmp_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else if (clear) begin
            vld_q         <= 1'b0;
            idx_q         <= '0;
            cmp_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else begin
            vld_q <= rd_en;
            idx_q <= rd_idx;
            if (vld_q)
                cmp_cnt <= cmp_cnt + 1'b1;
            if (miss) begin
                // err_cnt never returns to 0 once bumped, so it doubles as the first-miss flag
                if (err_cnt == '0)
                    first_err_idx <= idx_q;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_fifo_traffic_gen.sv
// Pattern writer/reader for the ddr3_ctrl_2port FIFO ports with run status.
// Ports: clk, reset, start, ddr3_init_done, wr/rd fifo ports, busy/done/pass/timeout, err_cnt, first_err_idx.
module ddr3_fifo_traffic_gen
    import ddr3_tg_pkg::*;
#(
    parameter int FIFO_DW       = 16,
    parameter int WORD_CNT      = 1024,
    parameter int DATA_BEGIN    = 1,
    parameter int SETTLE_CYCLES = 200,
    parameter int CLR_CYCLES    = 2,
    parameter int TIMEOUT       = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ddr3_init_done,
    output logic               wrfifo_clr,
    output logic               wrfifo_wren,
    output logic [FIFO_DW-1:0] wrfifo_din,
    input  logic               wrfifo_full,
    output logic               rdfifo_clr,
    output logic               rdfifo_rden,
    input  logic [FIFO_DW-1:0] rdfifo_dout,
    input  logic               rdfifo_empty,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [15:0]        err_cnt,
    output logic [15:0]        first_err_idx
);

    localparam logic [CNT_W-1:0] WC = CNT_W'(WORD_CNT);
    localparam logic [CNT_W-1:0] SC = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CC = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT - 1);

    tg_state_t        state;
    logic             init_s1, init_s2;
    logic [CNT_W-1:0] wr_idx, rd_idx, cnt, prog_cnt, cmp_cnt;
    logic             wr_go, rd_go, xfer, run_req, abort;

    // FIFO strobes are gated by full/empty in the same cycle so a write
    // can never land on a full wr_fifo nor a read on an empty rd_fifo.
    assign wr_go   = (state == S_WRITE) && !wrfifo_full && (wr_idx < WC);
    assign rd_go   = (state == S_READ) && !rdfifo_empty && (rd_idx < WC);
    assign xfer    = (state == S_WRITE) || (state == S_READ);
    assign run_req = start && ((state == S_IDLE) || (state == S_DONE));
    assign abort   = xfer && !wr_go && !rd_go && (prog_cnt == TO);

    assign wrfifo_wren = wr_go;
    assign rdfifo_rden = rd_go;
    assign wrfifo_din  = (state == S_WRITE) ?
                         FIFO_DW'(DATA_BEGIN) + FIFO_DW'(wr_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_s1 <= 1'b0;
            init_s2 <= 1'b0;
        end else begin
            init_s1 <= ddr3_init_done;
            init_s2 <= init_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wrfifo_clr <= 1'b1;
            rdfifo_clr <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            cnt        <= '0;
            prog_cnt   <= '0;
        end else begin
            prog_cnt <= (xfer && !(wr_go || rd_go)) ? prog_cnt + 1'b1 : '0;
            if (run_req) begin
                state      <= S_WAIT_INIT;
                wrfifo_clr <= 1'b0;
                rdfifo_clr <= 1'b0;
                busy       <= 1'b1;
                done       <= 1'b0;
                pass       <= 1'b0;
                timeout    <= 1'b0;
                wr_idx     <= '0;
                rd_idx     <= '0;
                cnt        <= '0;
            end else if (abort) begin
                state   <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        wrfifo_clr <= 1'b1;
                        rdfifo_clr <= 1'b1;
                    end
                    S_WAIT_INIT: begin
                        if (init_s2)
                            state <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (wr_idx == WC) begin
                            state <= S_SETTLE1;
                            cnt   <= '0;
                        end else if (wr_go) begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                    S_SETTLE1: begin
                        if (cnt == SC) begin
                            state      <= S_RCLR;
                            cnt        <= '0;
                            rdfifo_clr <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RCLR: begin
                        if (cnt == CC) begin
                            state      <= S_SETTLE2;
                            cnt        <= '0;
                            rdfifo_clr <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_SETTLE2: begin
                        if (cnt == SC) begin
                            state  <= S_READ;
                            rd_idx <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_READ: begin
                        // finish only once the last delayed compare has retired
                        if (cmp_cnt == WC) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0);
                        end else if (rd_go) begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                    S_DONE: begin
                        done <= 1'b1;
                    end
                endcase
            end
        end
    end

    ddr3_tg_checker #(
        .FIFO_DW   (FIFO_DW),
        .DATA_BEGIN(DATA_BEGIN)
    ) u_checker (
        .clk          (clk),
        .reset        (reset),
        .clear        (run_req),
        .rd_en        (rd_go),
        .rd_idx       (rd_idx),
        .rd_data      (rdfifo_dout),
        .cmp_cnt      (cmp_cnt),
        .err_cnt      (err_cnt),
        .first_err_idx(first_err_idx)
    );

endmodule

// File: tb/tb_ddr3_fifo_traffic_gen.sv
// Bench for ddr3_fifo_traffic_gen with a behavioural wr/rd FIFO loopback.
// Channel 0: 1024 words from 1; channel 1: 32 words from 16'hFFF0.
module tb_ddr3_fifo_traffic_gen;

    logic clk = 1'b0;
    logic reset;
    logic start [2];
    logic init_done [2];
    logic full [2];
    logic force_empty [2];
    logic flip [2];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : ch
        logic        wclr, wren, rclr, rden, empty;
        logic        busy, done, pass, tmo;
        logic [15:0] din, dout, ecnt, fidx;
        logic [15:0] mem [1024];
        int          wcnt, rptr, viol;

        ddr3_fifo_traffic_gen #(
            .FIFO_DW      (16),
            .WORD_CNT     ((g == 0) ? 1024 : 32),
            .DATA_BEGIN   ((g == 0) ? 1 : 32'hFFF0),
            .SETTLE_CYCLES(20),
            .CLR_CYCLES   (2),
            .TIMEOUT      (500)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start[g]),
            .ddr3_init_done(init_done[g]),
            .wrfifo_clr    (wclr),
            .wrfifo_wren   (wren),
            .wrfifo_din    (din),
            .wrfifo_full   (full[g]),
            .rdfifo_clr    (rclr),
            .rdfifo_rden   (rden),
            .rdfifo_dout   (dout),
            .rdfifo_empty  (empty),
            .busy          (busy),
            .done          (done),
            .pass          (pass),
            .timeout       (tmo),
            .err_cnt       (ecnt),
            .first_err_idx (fidx)
        );

        assign empty = force_empty[g] || (rptr >= wcnt);

        always_ff @(posedge clk) begin
            if (reset) begin
                wcnt <= 0;
                rptr <= 0;
                viol <= 0;
                dout <= '0;
            end else begin
                viol <= viol + int'(wren && full[g]) + int'(rden && empty);
                if (wclr) begin
                    wcnt <= 0;
                end else if (wren) begin
                    if (wcnt < 1024)
                        mem[wcnt[9:0]] <= din;
                    wcnt <= wcnt + 1;
                end
                if (rclr) begin
                    rptr <= 0;
                end else if (rden) begin
                    dout <= mem[rptr[9:0]] ^ {15'd0, flip[g] && (rptr == 37)};
                    rptr <= rptr + 1;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            full[i] = 1'b0;
            force_empty[i] = 1'b0;
            flip[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget,
                             output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            ok = (g == 0) ? ch[0].done : ch[1].done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        init_done[0] = 1'b0;
        init_done[1] = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (ch[0].busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%0b exp=0", ch[0].busy); end
        vectors++; if (ch[0].done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%0b exp=0", ch[0].done); end
        vectors++; if (ch[0].pass !== 1'b0) begin miscompares++; $display("FAIL rst_pass got=%0b exp=0", ch[0].pass); end
        vectors++; if (ch[0].tmo !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got=%0b exp=0", ch[0].tmo); end
        vectors++; if (ch[0].wclr !== 1'b1) begin miscompares++; $display("FAIL rst_wrclr got=%0b exp=1", ch[0].wclr); end
        vectors++; if (ch[0].rclr !== 1'b1) begin miscompares++; $display("FAIL rst_rdclr got=%0b exp=1", ch[0].rclr); end
        vectors++; if (ch[0].wren !== 1'b0) begin miscompares++; $display("FAIL rst_wren got=%0b exp=0", ch[0].wren); end
        vectors++; if (ch[0].rden !== 1'b0) begin miscompares++; $display("FAIL rst_rden got=%0b exp=0", ch[0].rden); end
        vectors++; if (ch[0].din !== 16'h0) begin miscompares++; $display("FAIL rst_din got=%0h exp=0", ch[0].din); end
        vectors++; if (ch[0].ecnt !== 16'h0) begin miscompares++; $display("FAIL rst_errcnt got=%0h exp=0", ch[0].ecnt); end
        vectors++; if (ch[0].fidx !== 16'h0) begin miscompares++; $display("FAIL rst_firstidx got=%0h exp=0", ch[0].fidx); end
        do_reset();
    endtask

    task automatic test_nominal();
        int cyc;
        bit ok;
        do_reset();
        pulse_start(0);
        repeat (10) @(negedge clk);
        vectors++; if (ch[0].busy !== 1'b1) begin miscompares++; $display("FAIL wait_busy got=%0b exp=1", ch[0].busy); end
        vectors++; if (ch[0].wcnt != 0) begin miscompares++; $display("FAIL wait_nowrite got=%0d exp=0", ch[0].wcnt); end
        vectors++; if (ch[0].wclr !== 1'b0) begin miscompares++; $display("FAIL wait_wrclr got=%0b exp=0", ch[0].wclr); end
        init_done[0] = 1'b1;
        init_done[1] = 1'b1;
        wait_done(0, 5000, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL nom_done got=0 exp=1 within 5000 cycles"); end
        vectors++; if (ch[0].pass !== 1'b1) begin miscompares++; $display("FAIL nom_pass got=%0b exp=1", ch[0].pass); end
        vectors++; if (ch[0].busy !== 1'b0) begin miscompares++; $display("FAIL nom_busy got=%0b exp=0", ch[0].busy); end
        vectors++; if (ch[0].ecnt !== 16'h0) begin miscompares++; $display("FAIL nom_errcnt got=%0h exp=0", ch[0].ecnt); end
        vectors++; if (ch[0].wcnt != 1024) begin miscompares++; $display("FAIL nom_wrcount got=%0d exp=1024", ch[0].wcnt); end
        vectors++; if (ch[0].rptr != 1024) begin miscompares++; $display("FAIL nom_rdcount got=%0d exp=1024", ch[0].rptr); end
        vectors++; if (ch[0].mem[0] !== 16'd1) begin miscompares++; $display("FAIL nom_word0 got=%0h exp=1", ch[0].mem[0]); end
        vectors++; if (ch[0].mem[1023] !== 16'd1024) begin miscompares++; $display("FAIL nom_word1023 got=%0h exp=400", ch[0].mem[1023]); end
        vectors++; if (ch[0].viol != 0) begin miscompares++; $display("FAIL nom_fifo_viol got=%0d exp=0", ch[0].viol); end
    endtask

    task automatic test_bit_flip();
        int cyc;
        bit ok;
        do_reset();
        flip[0] = 1'b1;
        pulse_start(0);
        wait_done(0, 5000, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL flip_done got=0 exp=1 within 5000 cycles"); end
        vectors++; if (ch[0].pass !== 1'b0) begin miscompares++; $display("FAIL flip_pass got=%0b exp=0", ch[0].pass); end
        vectors++; if (ch[0].ecnt !== 16'd1) begin miscompares++; $display("FAIL flip_errcnt got=%0h exp=1", ch[0].ecnt); end
        vectors++; if (ch[0].fidx !== 16'd37) begin miscompares++; $display("FAIL flip_firstidx got=%0d exp=37", ch[0].fidx); end
        vectors++; if (ch[0].tmo !== 1'b0) begin miscompares++; $display("FAIL flip_timeout got=%0b exp=0", ch[0].tmo); end
        flip[0] = 1'b0;
    endtask

    task automatic test_full_stall();
        int cyc;
        int snap;
        int leaks;
        bit ok;
        do_reset();
        pulse_start(0);
        cyc = 0;
        while (cyc < 2000 && ch[0].wcnt < 300) begin
            @(negedge clk);
            cyc++;
        end
        vectors++; if (ch[0].wcnt < 300) begin miscompares++; $display("FAIL stall_reach got=%0d exp>=300", ch[0].wcnt); end
        full[0] = 1'b1;
        snap = ch[0].wcnt;
        leaks = 0;
        repeat (50) begin
            @(negedge clk);
            if (ch[0].wren) leaks++;
        end
        vectors++; if (leaks != 0) begin miscompares++; $display("FAIL stall_wren got=%0d exp=0", leaks); end
        vectors++; if (ch[0].wcnt != snap) begin miscompares++; $display("FAIL stall_hold got=%0d exp=%0d", ch[0].wcnt, snap); end
        full[0] = 1'b0;
        wait_done(0, 5000, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stall_done got=0 exp=1 within 5000 cycles"); end
        vectors++; if (ch[0].pass !== 1'b1) begin miscompares++; $display("FAIL stall_pass got=%0b exp=1", ch[0].pass); end
        vectors++; if (ch[0].wcnt != 1024) begin miscompares++; $display("FAIL stall_wrcount got=%0d exp=1024", ch[0].wcnt); end
        vectors++; if (ch[0].viol != 0) begin miscompares++; $display("FAIL stall_viol got=%0d exp=0", ch[0].viol); end
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        do_reset();
        force_empty[0] = 1'b1;
        pulse_start(0);
        wait_done(0, 4000, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL to_done got=0 exp=1 within 4000 cycles"); end
        vectors++; if (cyc < 1563 || cyc > 1573) begin miscompares++; $display("FAIL to_latency got=%0d exp=1563..1573", cyc); end
        vectors++; if (ch[0].tmo !== 1'b1) begin miscompares++; $display("FAIL to_timeout got=%0b exp=1", ch[0].tmo); end
        vectors++; if (ch[0].pass !== 1'b0) begin miscompares++; $display("FAIL to_pass got=%0b exp=0", ch[0].pass); end
        vectors++; if (ch[0].busy !== 1'b0) begin miscompares++; $display("FAIL to_busy got=%0b exp=0", ch[0].busy); end
        vectors++; if (ch[0].rptr != 0) begin miscompares++; $display("FAIL to_reads got=%0d exp=0", ch[0].rptr); end
        force_empty[0] = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        bit ok;
        do_reset();
        pulse_start(1);
        wait_done(1, 2000, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_done got=0 exp=1 within 2000 cycles"); end
        vectors++; if (ch[1].pass !== 1'b1) begin miscompares++; $display("FAIL wrap_pass got=%0b exp=1", ch[1].pass); end
        vectors++; if (ch[1].ecnt !== 16'h0) begin miscompares++; $display("FAIL wrap_errcnt got=%0h exp=0", ch[1].ecnt); end
        vectors++; if (ch[1].wcnt != 32) begin miscompares++; $display("FAIL wrap_wrcount got=%0d exp=32", ch[1].wcnt); end
        vectors++; if (ch[1].mem[0] !== 16'hFFF0) begin miscompares++; $display("FAIL wrap_word0 got=%0h exp=fff0", ch[1].mem[0]); end
        vectors++; if (ch[1].mem[15] !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_word15 got=%0h exp=ffff", ch[1].mem[15]); end
        vectors++; if (ch[1].mem[16] !== 16'h0000) begin miscompares++; $display("FAIL wrap_word16 got=%0h exp=0", ch[1].mem[16]); end
        vectors++; if (ch[1].mem[31] !== 16'h000F) begin miscompares++; $display("FAIL wrap_word31 got=%0h exp=f", ch[1].mem[31]); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int snap;
        bit ok;
        do_reset();
        pulse_start(0);
        cyc = 0;
        while (cyc < 3000 && ch[0].rptr < 100) begin
            @(negedge clk);
            cyc++;
        end
        vectors++; if (ch[0].rptr < 100) begin miscompares++; $display("FAIL mid_reach got=%0d exp>=100", ch[0].rptr); end
        snap = ch[0].rptr;
        pulse_start(0);
        repeat (5) @(negedge clk);
        vectors++; if (ch[0].busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got=%0b exp=1", ch[0].busy); end
        vectors++; if (ch[0].wcnt != 1024) begin miscompares++; $display("FAIL mid_norestart got=%0d exp=1024", ch[0].wcnt); end
        vectors++; if (ch[0].rptr <= snap) begin miscompares++; $display("FAIL mid_reads got=%0d exp>%0d", ch[0].rptr, snap); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (ch[0].busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got=%0b exp=0", ch[0].busy); end
        vectors++; if (ch[0].done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done got=%0b exp=0", ch[0].done); end
        vectors++; if (ch[0].rden !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rden got=%0b exp=0", ch[0].rden); end
        vectors++; if (ch[0].wclr !== 1'b1) begin miscompares++; $display("FAIL mid_rst_wrclr got=%0b exp=1", ch[0].wclr); end
        vectors++; if (ch[0].rclr !== 1'b1) begin miscompares++; $display("FAIL mid_rst_rdclr got=%0b exp=1", ch[0].rclr); end
        reset = 1'b0;
        @(negedge clk);
        pulse_start(0);
        wait_done(0, 5000, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rerun_done got=0 exp=1 within 5000 cycles"); end
        vectors++; if (ch[0].pass !== 1'b1) begin miscompares++; $display("FAIL rerun_pass got=%0b exp=1", ch[0].pass); end
        vectors++; if (ch[0].wcnt != 1024) begin miscompares++; $display("FAIL rerun_wrcount got=%0d exp=1024", ch[0].wcnt); end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            init_done[i] = 1'b0;
            full[i] = 1'b0;
            force_empty[i] = 1'b0;
            flip[i] = 1'b0;
        end
        test_reset();
        test_nominal();
        test_bit_flip();
        test_full_stall();
        test_timeout();
        test_wrap();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
